reset_sequencer: RTL and testbench
==================================

// Module: reset_sequencer
// PURPOSE
//  Multi-source reset controller. Synchronizes NUM_REQ asynchronous reset requests into clk.
//  Enforces a minimum hold time, then releases NUM_OUT reset domains one at a time in index order.
//  Generalises the single-line N-stage synchronizer with staged release, re-trigger, cause
//  capture and an event counter. Sits at the top of each clock region, driving downstream sync resets.
// PARAMETERS
//  NUM_REQ       2   number of asynchronous request inputs (>=1)
//  NUM_OUT       4   number of sequenced reset outputs (>=1)
//  SYNC_DEPTH    2   synchronizer flops per request line (>=2)
//  HOLD_CYCLES  16   minimum cycles all outputs stay asserted after last request drops (>=1)
//  STAGE_CYCLES  8   cycles between consecutive output releases (>=1)
//  CNT_W         8   width of saturating reset-event counter
// PORTS
//  clk          in   1           clock
//  rst          in   1           synchronous, active-high reset
//  req_in       in   NUM_REQ     async active-high reset requests, any pulse width >= 1 clk period
//  sw_req       in   1           synchronous 1-cycle software reset request (not synchronized)
//  rst_out      out  NUM_OUT     active-high reset per domain; bit 0 released first
//  ready        out  1           1 when all rst_out are deasserted (state RUN)
//  cause        out  NUM_REQ+1   request sources seen in current/last HOLD; bit NUM_REQ = sw_req
//  event_count  out  CNT_W       number of HOLD entries caused by req_in/sw_req, saturating
// BEHAVIOUR
//  - Reset (rst=1 at edge): rst_out=all 1, ready=0, cause=0, event_count=0, sync flops=0.
//    Also: state=HOLD, hold cnt=HOLD_CYCLES-1, stage idx=0. rst has priority over every input.
//  - Sync: req_in[i] passes through SYNC_DEPTH flops; req_sync = OR of last stages, OR sw_req.
//    req_in rising before edge 1 -> rst_out all 1 after edge SYNC_DEPTH+1; sw_req -> after next edge.
//  - FSM states: HOLD, RELEASE, RUN; all outputs registered.
//  - HOLD: rst_out=all 1, ready=0.
//      req_sync=1 -> reload cnt=HOLD_CYCLES-1.
//      Else if cnt==0 -> RELEASE, idx=0, scnt=STAGE_CYCLES-1.
//      Else cnt--.
//  - RELEASE: scnt counts down to 0; at 0: rst_out[idx]<=0.
//      idx==NUM_OUT-1 -> RUN and ready<=1 on the same edge.
//      Otherwise idx++, scnt reloads.
//  - RUN: holds rst_out=0, ready=1 until a request.
//  - Any req_sync=1 in RELEASE or RUN -> next edge: HOLD, rst_out=all 1, ready=0.
//      Also: cnt=HOLD_CYCLES-1, idx=0, event_count+1 (saturates at 2^CNT_W-1).
//  - Timing from first edge with rst=0 and no requests:
//      rst_out[k] falls at edge HOLD_CYCLES+(k+1)*STAGE_CYCLES.
//      ready rises with rst_out[NUM_OUT-1].
//  - cause:
//      On HOLD entry from RELEASE/RUN, overwritten with active request bits (last sync stage, sw_req).
//      While in HOLD, new active bits are OR-ed in.
//      Held unchanged in RELEASE/RUN.
//  - Requests in HOLD extend HOLD only; they are not new events (no count increment).
//  - rst_out bits never toggle individually back to 1; reassertion is always all-at-once via HOLD.
//  - Once deasserted in a release pass, a bit stays 0 until the next HOLD.
// TESTING (defaults unless stated)
//  1 rst=1 5 cyc, req_in=0 -> rst_out=4'hF, ready=0.
//    After rst drops, rst_out[0..3] fall at edges 24/32/40/48; ready=1 at edge 48; event_count=0.
//  2 In RUN, 1-cycle pulse on req_in[1] -> rst_out=4'hF at edge 3 after pulse, cause=3'b010,
//    event_count=1; rst_out[0] falls 24 edges later.
//  3 req_in[0] held 100 cyc -> HOLD throughout; rst_out[0] falls 16+8 edges after req_sync drops.
//  4 sw_req after rst_out[1:0] released (RELEASE) -> next edge rst_out=4'hF, cause=3'b100,
//    event_count+1, full 24..48 release sequence restarts.
//  5 sw_req and rst=1 same edge -> reset wins: event_count=0, cause=0.
//  6 CNT_W=2, 5 separate req events each completing release -> event_count=3 (saturated).

Source files
------------

// File: rtl/reset_sequencer.sv
// -----------------------------------------------------------------------------
// reset_sequencer
//
// Multi-source reset controller for one clock region. Asynchronous reset
// requests are synchronized into clk, combined with a synchronous software
// request, and used to hold every downstream reset domain asserted for a
// minimum time. Once the requests have gone quiet the domains are released
// one at a time, lowest index first, with a fixed spacing between releases.
// The sources seen during the most recent hold window are captured in
// `cause`, and every hold entered from a released/running condition bumps a
// saturating event counter.
//
// Ports
//   clk          clock
//   rst          synchronous active-high reset, overrides every other input
//   req_in       asynchronous active-high reset requests (one per source)
//   sw_req       synchronous single-cycle software reset request
//   rst_out      active-high reset per domain, bit 0 released first
//   ready        high once every rst_out bit has been released
//   cause        request sources seen in the current/last hold window;
//                bit NUM_REQ is the software request
//   event_count  saturating count of hold entries from RELEASE or RUN
// -----------------------------------------------------------------------------
//
// state      | meaning
// -----------+------------------------------------------------------------
// ST_HOLD    | all domains in reset; waiting for HOLD_CYCLES quiet cycles
// ST_RELEASE | releasing domains one per STAGE_CYCLES, lowest index first
// ST_RUN     | all domains released, ready=1, watching for new requests
//
module reset_sequencer #(
  parameter int NUM_REQ      = 2,
  parameter int NUM_OUT      = 4,
  parameter int SYNC_DEPTH   = 2,
  parameter int HOLD_CYCLES  = 16,
  parameter int STAGE_CYCLES = 8,
  parameter int CNT_W        = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_REQ-1:0] req_in,
  input  logic               sw_req,
  output logic [NUM_OUT-1:0] rst_out,
  output logic               ready,
  output logic [NUM_REQ:0]   cause,
  output logic [CNT_W-1:0]   event_count
);

  localparam int HOLD_W  = (HOLD_CYCLES  > 1) ? $clog2(HOLD_CYCLES)  : 1;
  localparam int STAGE_W = (STAGE_CYCLES > 1) ? $clog2(STAGE_CYCLES) : 1;
  localparam int IDX_W   = (NUM_OUT      > 1) ? $clog2(NUM_OUT)      : 1;

  localparam logic [HOLD_W-1:0]  HOLD_LOAD  = HOLD_W'(HOLD_CYCLES - 1);
  localparam logic [HOLD_W-1:0]  HOLD_ONE   = HOLD_W'(1);
  localparam logic [STAGE_W-1:0] STAGE_LOAD = STAGE_W'(STAGE_CYCLES - 1);
  localparam logic [STAGE_W-1:0] STAGE_ONE  = STAGE_W'(1);
  localparam logic [IDX_W-1:0]   IDX_LAST   = IDX_W'(NUM_OUT - 1);
  localparam logic [IDX_W-1:0]   IDX_ONE    = IDX_W'(1);
  localparam logic [CNT_W-1:0]   CNT_ONE    = CNT_W'(1);
  localparam logic [CNT_W-1:0]   CNT_MAX    = '1;

  typedef enum logic [1:0] {
    ST_HOLD    = 2'd0,
    ST_RELEASE = 2'd1,
    ST_RUN     = 2'd2
  } state_t;

  // ---------------------------------------------------------------------------
  // Request synchronizers: one SYNC_DEPTH-deep chain per request line.
  // ---------------------------------------------------------------------------
  logic [NUM_REQ-1:0] sync_q [SYNC_DEPTH];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int d = 0; d < SYNC_DEPTH; d++) begin
        sync_q[d] <= '0;
      end
    end else begin
      sync_q[0] <= req_in;
      for (int d = 1; d < SYNC_DEPTH; d++) begin
        sync_q[d] <= sync_q[d-1];
      end
    end
  end

  logic [NUM_REQ-1:0] req_last;
  logic [NUM_REQ:0]   req_bits;
  logic               req_sync;

  // sw_req is already synchronous, so it joins after the synchronizers.
  assign req_last = sync_q[SYNC_DEPTH-1];
  assign req_bits = {sw_req, req_last};
  assign req_sync = |req_bits;

  // ---------------------------------------------------------------------------
  // Sequencer state
  // ---------------------------------------------------------------------------
  state_t              state_q,     state_d;
  logic [HOLD_W-1:0]   hold_cnt_q,  hold_cnt_d;
  logic [STAGE_W-1:0]  stage_cnt_q, stage_cnt_d;
  logic [IDX_W-1:0]    idx_q,       idx_d;
  logic [NUM_OUT-1:0]  rst_out_q,   rst_out_d;
  logic                ready_q,     ready_d;
  logic [NUM_REQ:0]    cause_q,     cause_d;
  logic [CNT_W-1:0]    event_cnt_q, event_cnt_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_HOLD;
      hold_cnt_q  <= HOLD_LOAD;
      stage_cnt_q <= STAGE_LOAD;
      idx_q       <= '0;
      rst_out_q   <= '1;
      ready_q     <= 1'b0;
      cause_q     <= '0;
      event_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      hold_cnt_q  <= hold_cnt_d;
      stage_cnt_q <= stage_cnt_d;
      idx_q       <= idx_d;
      rst_out_q   <= rst_out_d;
      ready_q     <= ready_d;
      cause_q     <= cause_d;
      event_cnt_q <= event_cnt_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    hold_cnt_d  = hold_cnt_q;
    stage_cnt_d = stage_cnt_q;
    idx_d       = idx_q;
    rst_out_d   = rst_out_q;
    ready_d     = ready_q;
    cause_d     = cause_q;
    event_cnt_d = event_cnt_q;

    case (state_q)
      ST_HOLD: begin
        rst_out_d = '1;
        ready_d   = 1'b0;
        // Requests arriving while already held only stretch the hold window
        // and accumulate into cause; they are not counted as new events.
        if (req_sync) begin
          hold_cnt_d = HOLD_LOAD;
          cause_d    = cause_q | req_bits;
        end else if (hold_cnt_q == '0) begin
          state_d     = ST_RELEASE;
          idx_d       = '0;
          stage_cnt_d = STAGE_LOAD;
        end else begin
          hold_cnt_d = hold_cnt_q - HOLD_ONE;
        end
      end

      ST_RELEASE, ST_RUN: begin
        if (req_sync) begin
          // Fresh reset event: reassert every domain at once and restart the
          // cause record from the sources active right now.
          state_d    = ST_HOLD;
          rst_out_d  = '1;
          ready_d    = 1'b0;
          hold_cnt_d = HOLD_LOAD;
          idx_d      = '0;
          cause_d    = req_bits;
          if (event_cnt_q != CNT_MAX) begin
            event_cnt_d = event_cnt_q + CNT_ONE;
          end
        end else if (state_q == ST_RELEASE) begin
          if (stage_cnt_q == '0) begin
            rst_out_d[idx_q] = 1'b0;
            if (idx_q == IDX_LAST) begin
              state_d = ST_RUN;
              ready_d = 1'b1;
            end else begin
              idx_d       = idx_q + IDX_ONE;
              stage_cnt_d = STAGE_LOAD;
            end
          end else begin
            stage_cnt_d = stage_cnt_q - STAGE_ONE;
          end
        end
      end

      default: begin
        // Unreachable encoding: fall back to a full hold.
        state_d    = ST_HOLD;
        rst_out_d  = '1;
        ready_d    = 1'b0;
        hold_cnt_d = HOLD_LOAD;
        idx_d      = '0;
      end
    endcase
  end

  assign rst_out     = rst_out_q;
  assign ready       = ready_q;
  assign cause       = cause_q;
  assign event_count = event_cnt_q;

endmodule

// File: tb/tb_reset_sequencer.sv
// -----------------------------------------------------------------------------
// tb_reset_sequencer
//
// Directed table of checkpoints for the default configuration, a randomized
// run against a timestamp-based reference model, and a short sequence on a
// second instance with a 2-bit event counter to exercise saturation.
// -----------------------------------------------------------------------------
module tb_reset_sequencer;

  localparam int NUM_REQ    = 2;
  localparam int NUM_OUT    = 4;
  localparam int SYNC_DEPTH = 2;
  localparam int HOLD       = 16;
  localparam int STAGE      = 8;
  localparam int CNT_W      = 8;
  localparam int S_CAP      = 100000;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Main instance (default parameters)
  logic               rst = 1'b1;
  logic [NUM_REQ-1:0] req_in = '0;
  logic               sw_req = 1'b0;
  logic [NUM_OUT-1:0] rst_out;
  logic               ready;
  logic [NUM_REQ:0]   cause;
  logic [CNT_W-1:0]   event_count;

  reset_sequencer #(
    .NUM_REQ(NUM_REQ), .NUM_OUT(NUM_OUT), .SYNC_DEPTH(SYNC_DEPTH),
    .HOLD_CYCLES(HOLD), .STAGE_CYCLES(STAGE), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .rst(rst), .req_in(req_in), .sw_req(sw_req),
    .rst_out(rst_out), .ready(ready), .cause(cause), .event_count(event_count)
  );

  // Saturation instance (CNT_W = 2)
  logic               rst2 = 1'b1;
  logic [NUM_REQ-1:0] req2 = '0;
  logic               sw2 = 1'b0;
  logic [NUM_OUT-1:0] rst_out2;
  logic               ready2;
  logic [NUM_REQ:0]   cause2;
  logic [1:0]         count2;

  reset_sequencer #(
    .NUM_REQ(NUM_REQ), .NUM_OUT(NUM_OUT), .SYNC_DEPTH(SYNC_DEPTH),
    .HOLD_CYCLES(HOLD), .STAGE_CYCLES(STAGE), .CNT_W(2)
  ) dut_sat (
    .clk(clk), .rst(rst2), .req_in(req2), .sw_req(sw2),
    .rst_out(rst_out2), .ready(ready2), .cause(cause2), .event_count(count2)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Reference model: m_s counts edges since the last time a request was seen
  // (or since reset). Everything observable follows from that age:
  //   held while m_s < HOLD, domain k free once m_s >= HOLD+(k+1)*STAGE.
  // Request visibility is modelled as a SYNC_DEPTH-edge delay line (queue).
  // ---------------------------------------------------------------------------
  int                 m_s;
  logic [NUM_REQ:0]   m_cause;
  int                 m_cnt;
  logic [NUM_REQ-1:0] m_hist[$];
  logic [NUM_REQ-1:0] m_dly;
  logic [NUM_REQ:0]   m_bits;

  task automatic model_reset();
    m_s     = 0;
    m_cause = '0;
    m_cnt   = 0;
    m_hist.delete();
    for (int i = 0; i < SYNC_DEPTH; i++) m_hist.push_back('0);
  endtask

  always @(posedge clk) begin
    if (rst) begin
      model_reset();
    end else begin
      m_dly = m_hist.pop_front();
      m_hist.push_back(req_in);
      m_bits = {sw_req, m_dly};
      if (|m_bits) begin
        if (m_s < HOLD) begin
          m_cause = m_cause | m_bits;
        end else begin
          m_cause = m_bits;
          if (m_cnt < (2**CNT_W) - 1) m_cnt++;
        end
        m_s = 0;
      end else if (m_s < S_CAP) begin
        m_s++;
      end
    end
  end

  function automatic logic [NUM_OUT-1:0] m_rst_out();
    logic [NUM_OUT-1:0] r;
    for (int k = 0; k < NUM_OUT; k++) r[k] = (m_s < HOLD + (k + 1) * STAGE);
    return r;
  endfunction

  task automatic compare_model(input int cyc);
    check($sformatf("model_rst_out@%0d", cyc), 32'(rst_out), 32'(m_rst_out()));
    check($sformatf("model_ready@%0d", cyc), 32'(ready), 32'(m_s >= HOLD + NUM_OUT * STAGE));
    check($sformatf("model_cause@%0d", cyc), 32'(cause), 32'(m_cause));
    check($sformatf("model_count@%0d", cyc), 32'(event_count), 32'(m_cnt));
  endtask

  int cyc_no = 0;

  task automatic drive(input logic r, input logic [NUM_REQ-1:0] q, input logic s, input int n);
    for (int i = 0; i < n; i++) begin
      rst = r; req_in = q; sw_req = s;
      @(posedge clk);
      #1;
      cyc_no++;
      compare_model(cyc_no);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Directed checkpoint table: apply inputs for n edges, then compare.
  // ---------------------------------------------------------------------------
  typedef struct {
    logic               r;
    logic [NUM_REQ-1:0] q;
    logic               s;
    int                 n;
    logic [NUM_OUT-1:0] e_rst;
    logic               e_rdy;
    logic [NUM_REQ:0]   e_cause;
    logic [CNT_W-1:0]   e_cnt;
  } vec_t;

  localparam int NVEC = 23;
  vec_t vecs[NVEC];

  function automatic vec_t mk(input logic r, input logic [1:0] q, input logic s, input int n,
                              input logic [3:0] e_rst, input logic e_rdy,
                              input logic [2:0] e_cause, input logic [7:0] e_cnt);
    vec_t v;
    v.r = r; v.q = q; v.s = s; v.n = n;
    v.e_rst = e_rst; v.e_rdy = e_rdy; v.e_cause = e_cause; v.e_cnt = e_cnt;
    return v;
  endfunction

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin : main
    logic r_r, r_s;
    logic [NUM_REQ-1:0] r_q;
    int k;

    model_reset();

    // Power-up release timing
    vecs[0]  = mk(1, 2'b00, 0,   5, 4'hF, 0, 3'b000, 0);
    vecs[1]  = mk(0, 2'b00, 0,  23, 4'hF, 0, 3'b000, 0);
    vecs[2]  = mk(0, 2'b00, 0,   1, 4'hE, 0, 3'b000, 0);
    vecs[3]  = mk(0, 2'b00, 0,   8, 4'hC, 0, 3'b000, 0);
    vecs[4]  = mk(0, 2'b00, 0,   8, 4'h8, 0, 3'b000, 0);
    vecs[5]  = mk(0, 2'b00, 0,   7, 4'h8, 0, 3'b000, 0);
    vecs[6]  = mk(0, 2'b00, 0,   1, 4'h0, 1, 3'b000, 0);
    vecs[7]  = mk(0, 2'b00, 0,  20, 4'h0, 1, 3'b000, 0);
    // One-cycle pulse on req_in[1]: visible at the third edge
    vecs[8]  = mk(0, 2'b10, 0,   1, 4'h0, 1, 3'b000, 0);
    vecs[9]  = mk(0, 2'b00, 0,   1, 4'h0, 1, 3'b000, 0);
    vecs[10] = mk(0, 2'b00, 0,   1, 4'hF, 0, 3'b010, 1);
    vecs[11] = mk(0, 2'b00, 0,  23, 4'hF, 0, 3'b010, 1);
    vecs[12] = mk(0, 2'b00, 0,   1, 4'hE, 0, 3'b010, 1);
    vecs[13] = mk(0, 2'b00, 0,   8, 4'hC, 0, 3'b010, 1);
    // Software request mid-release
    vecs[14] = mk(0, 2'b00, 1,   1, 4'hF, 0, 3'b100, 2);
    vecs[15] = mk(0, 2'b00, 0,  23, 4'hF, 0, 3'b100, 2);
    vecs[16] = mk(0, 2'b00, 0,   1, 4'hE, 0, 3'b100, 2);
    vecs[17] = mk(0, 2'b00, 0,  24, 4'h0, 1, 3'b100, 2);
    // Long request: HOLD throughout, release 24 edges after req_sync drops
    vecs[18] = mk(0, 2'b01, 0, 100, 4'hF, 0, 3'b001, 3);
    vecs[19] = mk(0, 2'b00, 0,  25, 4'hF, 0, 3'b001, 3);
    vecs[20] = mk(0, 2'b00, 0,   1, 4'hE, 0, 3'b001, 3);
    // rst and sw_req on the same edge
    vecs[21] = mk(1, 2'b00, 1,   1, 4'hF, 0, 3'b000, 0);
    vecs[22] = mk(0, 2'b00, 0,  48, 4'h0, 1, 3'b000, 0);

    for (int i = 0; i < NVEC; i++) begin
      drive(vecs[i].r, vecs[i].q, vecs[i].s, vecs[i].n);
      check($sformatf("row%0d_rst_out", i), 32'(rst_out), 32'(vecs[i].e_rst));
      check($sformatf("row%0d_ready", i), 32'(ready), 32'(vecs[i].e_rdy));
      check($sformatf("row%0d_cause", i), 32'(cause), 32'(vecs[i].e_cause));
      check($sformatf("row%0d_count", i), 32'(event_count), 32'(vecs[i].e_cnt));
    end

    // Randomized traffic against the model
    for (int i = 0; i < 4000; i++) begin
      r_r = ($urandom_range(0, 999) < 3);
      r_q = ($urandom_range(0, 99) < 2) ? NUM_REQ'($urandom_range(1, 3)) : '0;
      r_s = ($urandom_range(0, 199) == 0);
      drive(r_r, r_q, r_s, 1);
    end
    drive(0, 2'b00, 0, 1);

    // Counter saturation on the 2-bit instance
    rst2 = 1'b1; req2 = '0; sw2 = 1'b0;
    repeat (3) begin @(posedge clk); #1; end
    rst2 = 1'b0;
    k = 0;
    while (ready2 !== 1'b1 && k < 200) begin @(posedge clk); #1; k++; end
    check("sat_initial_latency", 32'(k), 32'(HOLD + NUM_OUT * STAGE));
    check("sat_initial_count", 32'(count2), 32'd0);

    for (int e = 1; e <= 5; e++) begin
      req2 = 2'b01;
      @(posedge clk); #1;
      req2 = 2'b00;
      k = 1;
      while (ready2 !== 1'b1 || k < 3) begin
        if (k >= 200) break;
        @(posedge clk); #1; k++;
      end
      // Visible at edge 3, then HOLD + NUM_OUT*STAGE edges of release
      check($sformatf("sat_ev%0d_latency", e), 32'(k), 32'(SYNC_DEPTH + 1 + HOLD + NUM_OUT * STAGE));
      check($sformatf("sat_ev%0d_count", e), 32'(count2), 32'((e < 3) ? e : 3));
      check($sformatf("sat_ev%0d_cause", e), 32'(cause2), 32'b001);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
